// File: rtl/press_mult_pkg.sv
// Shared state encodings and LED phase codes for the press-count multiply controller.
package press_mult_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_ENTER_A = 3'd1,
    ST_ENTER_B = 3'd2,
    ST_MULT    = 3'd3,
    ST_SHOW    = 3'd4
  } state_t;

  localparam logic [1:0] PH_A = 2'b01;
  localparam logic [1:0] PH_B = 2'b11;

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low key; emits a one-cycle pulse on each accepted press.
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic             sync0_q, sync1_q;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only advances while the synchronised sample disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync1_q != level_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        level_d = sync1_q;
        pulse_d = ~sync1_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sync0_q <= 1'b1;
      sync1_q <= 1'b1;
      level_q <= 1'b1;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= key_raw;
      sync1_q <= sync0_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_level   = level_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/press_mult_ctrl.sv
// Collects two operands from debounced key presses, multiplies them with an OP_W-cycle
// shift-add sequencer and shows status or product on LED.
module press_mult_ctrl
  import press_mult_pkg::*;
#(
  parameter int OP_W      = 4,
  parameter int DB_CYCLES = 500000
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [1:0]          KEY,
  output logic [2*OP_W-1:0]   LED,
  output logic                busy,
  output logic                result_valid
);

  localparam int P_W  = 2 * OP_W;
  localparam int IT_W = $clog2(OP_W);

  logic [1:0] key_lvl, key_pls;
  logic       inc_ev, adv_ev;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_adv (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .key_raw     (KEY[0]),
    .key_level   (key_lvl[0]),
    .press_pulse (key_pls[0])
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .key_raw     (KEY[1]),
    .key_level   (key_lvl[1]),
    .press_pulse (key_pls[1])
  );

  // A press pulse always coincides with the key level reading pressed.
  assign inc_ev = key_pls[1] & ~key_lvl[1];
  assign adv_ev = key_pls[0] & ~key_lvl[0];

  state_t            state_q, state_d;
  logic [OP_W-1:0]   cnt_a_q, cnt_a_d;
  logic [OP_W-1:0]   cnt_b_q, cnt_b_d;
  logic [P_W-1:0]    mcand_q, mcand_d;
  logic [OP_W-1:0]   mplier_q, mplier_d;
  logic [P_W-1:0]    acc_q, acc_d;
  logic [IT_W-1:0]   iter_q, iter_d;

  always_comb begin
    state_d  = state_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_a_d = '0;
        cnt_b_d = '0;
        acc_d   = '0;
        state_d = ST_ENTER_A;
      end
      ST_ENTER_A: begin
        if (inc_ev && cnt_a_q != '1) cnt_a_d = cnt_a_q + 1'b1;
        if (adv_ev) state_d = ST_ENTER_B;
      end
      ST_ENTER_B: begin
        if (inc_ev && cnt_b_q != '1) cnt_b_d = cnt_b_q + 1'b1;
        if (adv_ev) begin
          // Operands load from the post-increment value so a same-cycle increment counts.
          state_d  = ST_MULT;
          mcand_d  = P_W'(cnt_a_q);
          mplier_d = cnt_b_d;
          acc_d    = '0;
          iter_d   = '0;
        end
      end
      ST_MULT: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        iter_d   = iter_q + 1'b1;
        if (iter_q == IT_W'(OP_W - 1)) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (adv_ev) state_d = ST_CLEAR;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q  <= ST_CLEAR;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
    end
  end

  always_comb begin
    LED = '0;
    case (state_q)
      ST_ENTER_A: begin
        LED[P_W-1:OP_W] = cnt_a_q;
        LED[1:0]        = PH_A;
      end
      ST_ENTER_B, ST_MULT: begin
        LED[P_W-1:OP_W] = cnt_b_q;
        LED[1:0]        = PH_B;
      end
      ST_SHOW: LED = acc_q;
      default: LED = '0;
    endcase
  end

  assign busy         = (state_q == ST_MULT);
  assign result_valid = (state_q == ST_SHOW);

endmodule

// File: tb/tb_press_mult_ctrl.sv
// Directed bench for press_mult_ctrl with an abstract reference model checked every cycle.
module tb_press_mult_ctrl;

  localparam int OP_W = 4;
  localparam int DB   = 4;
  localparam int P_W  = 2 * OP_W;
  localparam int MAXV = (1 << OP_W) - 1;

  localparam int M_CLR = 0, M_A = 1, M_B = 2, M_MUL = 3, M_SH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     key = 2'b11;
  logic [P_W-1:0] led;
  logic           busy, rv;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  press_mult_ctrl #(.OP_W(OP_W), .DB_CYCLES(DB)) dut (
    .CLOCK_50     (clk),
    .RESET_N      (rst_n),
    .KEY          (key),
    .LED          (led),
    .busy         (busy),
    .result_valid (rv)
  );

  // Reference: operator-level state, two operands, a product computed with '*' after a
  // countdown, and per-key press detection from run lengths of delayed key samples.
  typedef struct packed {
    int         st;
    int         a;
    int         b;
    int         p;
    int         left;
    int         run0;
    int         run1;
    logic [1:0] h0;
    logic [1:0] h1;
    logic [1:0] lvl;
    logic [1:0] ev;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t n;
    n.st = M_CLR; n.a = 0; n.b = 0; n.p = 0; n.left = 0;
    n.run0 = 0; n.run1 = 0;
    n.h0 = 2'b11; n.h1 = 2'b11; n.lvl = 2'b11; n.ev = 2'b00;
    return n;
  endfunction

  function automatic model_t step(model_t cur, logic [1:0] k);
    model_t n = cur;
    int run [2];
    bit inc = cur.ev[1];
    bit adv = cur.ev[0];
    run[0] = cur.run0;
    run[1] = cur.run1;
    case (cur.st)
      M_CLR: begin n.a = 0; n.b = 0; n.p = 0; n.st = M_A; end
      M_A: begin
        if (inc) n.a = (cur.a < MAXV) ? cur.a + 1 : MAXV;
        if (adv) n.st = M_B;
      end
      M_B: begin
        if (inc) n.b = (cur.b < MAXV) ? cur.b + 1 : MAXV;
        if (adv) begin n.st = M_MUL; n.left = OP_W; end
      end
      M_MUL: begin
        n.left = cur.left - 1;
        if (n.left == 0) begin n.p = n.a * n.b; n.st = M_SH; end
      end
      M_SH: if (adv) n.st = M_CLR;
      default: n.st = M_CLR;
    endcase
    for (int i = 0; i < 2; i++) begin
      n.ev[i] = 1'b0;
      if (cur.h1[i] != cur.lvl[i]) begin
        run[i] = run[i] + 1;
        if (run[i] == DB) begin
          n.lvl[i] = cur.h1[i];
          n.ev[i]  = ~cur.h1[i];
          run[i]   = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    n.run0 = run[0];
    n.run1 = run[1];
    n.h1 = cur.h0;
    n.h0 = k;
    return n;
  endfunction

  always @(posedge clk) m <= rst_n ? step(m, key) : model_reset();

  function automatic int exp_led(model_t x);
    case (x.st)
      M_A:          return ((x.a << OP_W) | 1) & 8'hFF;
      M_B, M_MUL:   return ((x.b << OP_W) | 3) & 8'hFF;
      M_SH:         return x.p & 8'hFF;
      default:      return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("led", int'(led), exp_led(m));
      check("busy", int'(busy), int'(m.st == M_MUL));
      check("result_valid", int'(rv), int'(m.st == M_SH));
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int idx);
    key[idx] = 1'b0; cyc(8);
    key[idx] = 1'b1; cyc(8);
  endtask

  task automatic press_n(input int idx, input int n);
    for (int i = 0; i < n; i++) press(idx);
  endtask

  task automatic wait_mst(input int s);
    int n = 0;
    while (m.st != s && n < 100) begin @(negedge clk); n++; end
    check("wait_model_state", m.st, s);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(3);
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rv", int'(rv), 0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    cyc(3);
    check("enter_a_led", int'(led), 8'h01);

    // 3 x 5 = 15, busy for exactly OP_W cycles
    press_n(1, 3);
    press(0);
    press_n(1, 5);
    busy_cnt = 0;
    press(0);
    check("t1_busy_cycles", busy_cnt, 4);
    check("t1_led", int'(led), 8'h0F);
    check("t1_rv", int'(rv), 1);
    check("t1_model_prod", m.p, 15);
    press(0);

    // saturation: 20 presses -> 15, 15 x 15 = 225
    press_n(1, 20);
    check("t2_a_sat_led", int'(led), 8'hF1);
    press(0);
    press_n(1, 15);
    check("t2_b_led", int'(led), 8'hF3);
    press(0);
    check("t2_led", int'(led), 8'hE1);
    check("t2_model_prod", m.p, 225);
    press(0);

    // zero operands
    press(0);
    press(0);
    check("t3_led", int'(led), 8'h00);
    check("t3_rv", int'(rv), 1);
    press(0);
    check("t3_back_to_a", int'(led), 8'h01);

    // bounce rejected; long press counts once; release adds nothing
    key[1] = 1'b0; cyc(2);
    key[1] = 1'b1; cyc(10);
    check("t4_bounce", int'(led), 8'h01);
    key[1] = 1'b0; cyc(10);
    check("t4_press", int'(led), 8'h11);
    key[1] = 1'b1; cyc(10);
    check("t4_release", int'(led), 8'h11);

    // simultaneous increment and advance
    press(1);
    check("t5_a2", int'(led), 8'h21);
    key = 2'b00; cyc(8);
    key = 2'b11; cyc(8);
    check("t5_b_entered", int'(led), 8'h03);
    check("t5_model_a", m.a, 3);
    press_n(1, 3);
    check("t5_b3", int'(led), 8'h33);
    press(0);
    check("t5_prod", int'(led), 8'h09);
    press(0);

    // reset in the second MULT cycle
    press_n(1, 2);
    press(0);
    press_n(1, 3);
    key[0] = 1'b0;
    wait_mst(M_MUL);
    @(negedge clk);
    rst_n = 1'b0;
    key[0] = 1'b1;
    @(negedge clk);
    check("t6_rst_led", int'(led), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_rv", int'(rv), 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(12);
    check("t6_after_rst", int'(led), 8'h01);

    // increment press landing during MULT is dropped
    press_n(1, 2);
    press(0);
    press_n(1, 3);
    key[0] = 1'b0; cyc(2);
    key[1] = 1'b0; cyc(10);
    key = 2'b11; cyc(10);
    check("t6_mult_press_led", int'(led), 8'h06);
    check("t6_mult_press_rv", int'(rv), 1);
    check("t6_model_prod", m.p, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
